// File: rtl/add_seq.sv
// Multi-word adder/subtractor that time-shares one N-bit ripple-carry adder
// across W chunks, least-significant chunk first, with valid/ready handshakes.
module add_seq #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic           sub,
  input  logic           c_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] sum,
  output logic           c_out
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N*W-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]  cnt_q;
  logic           carry_q;

  logic [N-1:0]   op_a, op_b, chunk_sum;
  logic           chunk_carry;
  logic           accept;

  assign op_a = a_q[cnt_q*N +: N];
  assign op_b = b_q[cnt_q*N +: N];

  // The single shared N-bit ripple adder, one full-adder cell per bit.
  always_comb begin : ripple
    logic c;
    // NOTE: blocking assignments here are deliberate; c must carry each
    // cell's carry-out into the next cell within the same evaluation.
    c         = carry_q;
    chunk_sum = '0;
    for (int i = 0; i < N; i++) begin
      chunk_sum[i] = op_a[i] ^ op_b[i] ^ c;
      c            = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
    end
    chunk_carry = c;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Subtraction is fully captured by storing ~b and seeding the carry with 1,
  // so no separate mode flag has to travel with the operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : c_in;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q[cnt_q*N +: N] <= chunk_sum;
        carry_q             <= chunk_carry;
        // Park on the last chunk instead of wrapping.
        if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sum   = sum_q;
  assign c_out = carry_q;

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference.
module tb_add_seq;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int OW = N * W;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out;
  logic [OW-1:0] a, b, sum;

  int checks   = 0;
  int failures = 0;

  add_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word modular arithmetic, carry taken from bit OW.
  function automatic logic [OW:0] ref_op(input logic [OW-1:0] x, y, input logic s, ci);
    logic [OW:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (OW+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + (OW+1)'(ci);
    return r;
  endfunction

  // One full transaction; hold = cycles out_ready stays low once out_valid is up.
  task automatic do_op(input string tag, input logic [OW-1:0] av, bv,
                       input logic sv, cv, input int hold);
    logic [OW:0] exp;
    int          n;
    bit          ok;
    exp = ref_op(av, bv, sv, cv);
    n   = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, ":ready_wait"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; a = av; b = bv; sub = sv; c_in = cv; out_ready = 1'b0;
    tick();
    // Scramble everything after the accept: none of it may matter now.
    n = 0;
    while (!out_valid && n < W + 6) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; sub = 1'($urandom); c_in = 1'($urandom);
      tick(); n++;
    end
    check({tag, ":latency"}, 64'(n), 64'(W));
    if (!out_valid) begin in_valid = 1'b0; return; end
    check({tag, ":sum"},   64'(sum),   64'(exp[OW-1:0]));
    check({tag, ":c_out"}, 64'(c_out), 64'(exp[OW]));
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      tick();
      if (!out_valid || in_ready || sum !== exp[OW-1:0] || c_out !== exp[OW]) ok = 1'b0;
    end
    if (hold > 0) check({tag, ":hold_stable"}, 64'(ok), 64'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ":idle_ready"}, 64'({in_ready, out_valid}), 64'(2'b10));
    check({tag, ":sum_kept"},   64'(sum), 64'(exp[OW-1:0]));
  endtask

  initial begin
    bit ok;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_state", 64'({in_ready, out_valid, c_out}), 64'(3'b100));
    check("reset_sum",   64'(sum), 64'(0));

    // Directed corner cases.
    do_op("ovf_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    do_op("sub_neg",   32'h00000005, 32'h00000007, 1'b1, 1'b0, 0);
    do_op("sub_pos",   32'h00000007, 32'h00000005, 1'b1, 1'b0, 0);
    do_op("cin_only",  32'h00000000, 32'h00000000, 1'b0, 1'b1, 0);
    do_op("sub_zero",  32'h00000000, 32'h00000000, 1'b1, 1'b0, 0);
    do_op("backpress", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 10);
    check("backpress_val", 64'(sum), 64'(32'h23456789));

    // Reset in the second RUN cycle discards the operation.
    in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b0; c_in = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", 64'({in_ready, out_valid, c_out}), 64'(3'b100));
    check("mid_rst_sum",   64'(sum), 64'(0));
    ok = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (out_valid) ok = 1'b0;
    end
    check("mid_rst_no_valid", 64'(ok), 64'(1));
    do_op("post_rst", 32'h00000010, 32'h00000020, 1'b0, 1'b0, 0);
    check("post_rst_val", 64'(sum), 64'(32'h00000030));

    // Random operations with random idle gaps and backpressure.
    for (int k = 0; k < 1000; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      do_op("rand", $urandom, $urandom, 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
